// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the shared single-port memory: fixed CPU priority with a
// DMA starvation limit; every access runs a four-cycle IDLE/ACCESS/RESP/DONE sequence.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_r;
  logic [3:0] starve_cnt_r;
  logic       op_we_r;
  logic       any_req_s;
  logic       grant_dma_s;

  // Arbitration decision: DMA wins alone, or once the CPU has starved it long enough
  always_comb begin
    any_req_s   = cpu_req | dma_req;
    grant_dma_s = 1'b0;
    if (dma_req && !cpu_req) begin
      grant_dma_s = 1'b1;
    end else if (dma_req && cpu_req && (starve_cnt_r >= LIMIT)) begin
      grant_dma_s = 1'b1;
    end else begin
      grant_dma_s = 1'b0;
    end
  end

  // Transaction sequencer with all bus and requester outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      starve_cnt_r <= 4'd0;
      op_we_r      <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_ack      <= 1'b0;
      dma_ack      <= 1'b0;
      cpu_rdata    <= '0;
      dma_rdata    <= '0;
      busy         <= 1'b0;
      owner        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner     <= grant_dma_s;
            mem_addr  <= grant_dma_s ? dma_addr  : cpu_addr;
            mem_wdata <= grant_dma_s ? dma_wdata : cpu_wdata;
            mem_we    <= grant_dma_s ? dma_we    : cpu_we;
            op_we_r   <= grant_dma_s ? dma_we    : cpu_we;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state_r   <= ACCESS;
            // Count CPU wins only while DMA is actually waiting; saturate at 15
            if (!grant_dma_s && dma_req) begin
              if (starve_cnt_r != 4'hF) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
              end else begin
                starve_cnt_r <= starve_cnt_r;
              end
            end else begin
              starve_cnt_r <= 4'd0;
            end
          end else begin
            mem_en  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          state_r <= RESP;
        end
        RESP: begin
          if (owner) begin
            dma_ack <= 1'b1;
            if (!op_we_r) begin
              dma_rdata <= mem_rdata;
            end else begin
              dma_rdata <= dma_rdata;
            end
          end else begin
            cpu_ack <= 1'b1;
            if (!op_we_r) begin
              cpu_rdata <= mem_rdata;
            end else begin
              cpu_rdata <= cpu_rdata;
            end
          end
          state_r <= DONE;
        end
        DONE: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
